// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch, load/store) arbiter in front of one variable-latency memory port.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_gnt,
    output logic                    if_rvalid,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    ls_req,
    input  logic                    ls_we,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_be,
    output logic                    ls_gnt,
    output logic                    ls_rvalid,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic                    err
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SERVE_IF = 2'd1;
    localparam logic [1:0] SERVE_LS = 2'd2;

    logic [1:0]          state_reg;
    logic                last_ls_reg;
    logic                pick_ls;
    logic                timeout_hit;
    logic [BE_WIDTH-1:0] be_next;

    // Load/store wins unless it won last time and fetch is also waiting.
    assign pick_ls = ls_req && (!if_req || !last_ls_reg);
    assign busy    = (state_reg != IDLE);

    for (genvar gi = 0; gi < BE_WIDTH; gi++) begin : g_be
        assign be_next[gi] = pick_ls ? ls_be[gi] : 1'b1;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_reg;

    // A completing memory beat always beats the watchdog in the same cycle.
    assign timeout_hit = busy && !mem_ready && (cnt_reg == CNT_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            err     <= 1'b0;
        end else begin
            err <= timeout_hit;
            if (!busy) begin
                cnt_reg <= '0;
            end else if (!mem_ready && !timeout_hit) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            last_ls_reg <= 1'b0;
            if_gnt      <= 1'b0;
            if_rvalid   <= 1'b0;
            if_rdata    <= '0;
            ls_gnt      <= 1'b0;
            ls_rvalid   <= 1'b0;
            ls_rdata    <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
        end else begin
            if_gnt    <= 1'b0;
            ls_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (if_req || ls_req) begin
                        state_reg   <= pick_ls ? SERVE_LS : SERVE_IF;
                        last_ls_reg <= pick_ls;
                        ls_gnt      <= pick_ls;
                        if_gnt      <= !pick_ls;
                        mem_req     <= 1'b1;
                        mem_we      <= pick_ls && ls_we;
                        mem_addr    <= pick_ls ? ls_addr : if_addr;
                        mem_wdata   <= pick_ls ? ls_wdata : '0;
                        mem_be      <= be_next;
                    end
                end
                default: begin
                    if (mem_ready || timeout_hit) begin
                        state_reg <= IDLE;
                        mem_req   <= 1'b0;
                        // An aborted access returns zero data to its owner.
                        if (state_reg == SERVE_LS) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= mem_ready ? mem_rdata : '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule
